matrix_storage_writer: RTL and testbench
========================================

# matrix_storage_writer

Downstream stage of the input subsystem. It consumes the storage write interface: one request carrying metadata, then a stream of matrix elements. It lays each matrix into a fixed-size slot of the shared storage RAM: two name words, row-major data, and finally the header word. The header is written last, so a slot reads as occupied (header non-zero) only after a complete, successful write.

## Interface
- BLOCK_SIZE, 1152, words per matrix slot
- DATA_WIDTH, 32, element/RAM word width
- ADDR_WIDTH, 14, storage RAM address width
- clk  in  1  system clock, all logic on rising edge
- rst_n  in  1  asynchronous, active-low reset
- write_request  in  1  request to store a matrix, sampled only while write_ready=1
- write_ready  out  1  block idle, request will be accepted
- matrix_id  in  3  slot index 0..7, latched with request
- actual_rows  in  8  row count, latched with request
- actual_cols  in  8  column count, latched with request
- matrix_name  in  8x8 [0:7]  ASCII name, latched with request
- data_in  in  DATA_WIDTH  element value
- data_valid  in  1  data_in valid
- writer_ready  out  1  element accepted on edge where data_valid=1
- write_done  out  1  one-cycle pulse, matrix fully committed
- error  out  1  one-cycle pulse, request rejected
- ram_wr_en  out  1  storage RAM write strobe
- ram_wr_addr  out  ADDR_WIDTH  storage RAM write address
- ram_wr_data  out  DATA_WIDTH  storage RAM write data

## Operation
- Reset (async): state=RST_WAIT. All outputs are 0 while in reset and in RST_WAIT.
- States and transitions:
  - RST_WAIT→IDLE: unconditional.
  - IDLE→NAME1: write_request and dimensions valid.
  - IDLE→ERR: write_request and dimensions invalid.
  - NAME1→NAME2→DATA: unconditional.
  - DATA→HDR: on the edge accepting the last element.
  - HDR→DONE: unconditional.
  - DONE→IDLE and ERR→IDLE: unconditional.
- On acceptance, latch matrix_id, rows, cols and name.
  - base = matrix_id*BLOCK_SIZE, ADDR_WIDTH bits.
  - total = rows*cols, 16 bits.
  - Reset idx to 0.
- Valid dimensions: rows≠0, cols≠0, and total+3 ≤ BLOCK_SIZE. Compare in 17 bits.
- Slot layout:
  - base+0 = {16'h0, rows, cols}
  - base+1 = {name[0],name[1],name[2],name[3]} (name[0] in MSB)
  - base+2 = {name[4..7]}
  - base+3+k = element k, row-major
- Output decodes are Moore from the state register, except the DATA-state RAM write:
  - IDLE: write_ready=1.
  - NAME1: ram_wr_en=1, addr base+1.
  - NAME2: ram_wr_en=1, addr base+2.
  - DATA: writer_ready=1, and combinationally ram_wr_en=data_valid, addr=base+3+idx, data=data_in. idx increments on each accepted element.
  - HDR: ram_wr_en=1, addr base, header word.
  - DONE: write_done=1.
  - ERR: error=1, no RAM write.
- Ignored inputs:
  - data_valid outside DATA.
  - write_request outside IDLE.
  - Input changes after latch.
- Reset mid-operation: abort immediately with no header write. The slot header keeps its prior value, and partial data may remain.

## Timing
- Request sampled at edge T.
- Cycle T+1: NAME1. Cycle T+2: NAME2. From T+3: DATA.
- Elements are accepted at most one per cycle. Bubbles on data_valid are allowed and add no penalty.
- Last element accepted at edge E: HDR in cycle E+1, write_done in E+2, write_ready=1 from E+3.
- A minimal 1x1 matrix with continuous data returns write_ready 6 cycles after the request edge.
- Rejected request: error in cycle T+1, write_ready=1 in T+2.
- After rst_n deassert: RST_WAIT for one cycle, then write_ready=1 from the second cycle.

## Test plan
- **Basic write**
  - Stimulus: id=1, 2x3, name "ABCDEFGH", data 1..6 continuous.
  - Response: writes 1153=0x41424344, 1154=0x45464748, 1155..1160=1..6, then 1152=0x00000203; write_done one cycle later, single pulse.
- **Backpressure/bubbles**
  - Stimulus: id=0, 2x2, data_valid pattern 1,0,0,1,1,0,1 with values 10,20,30,40 on the valid cycles.
  - Response: exactly 4 data writes at addr 3..6 with values 10,20,30,40; header 0x00000202 written after the 4th.
- **Rejections**
  - Stimulus: (a) rows=0, cols=5; (b) 34x34, where 1156+3>1152.
  - Response: error pulse, zero ram_wr_en cycles, write_ready back in 2 cycles. 33x34 (1122) is accepted.
- **Max slot**
  - Stimulus: id=7, 33x34.
  - Response: base 8064; last data addr 9188; header 0x00002122 at 8064.
- **Reset mid-DATA**
  - Stimulus: assert rst_n after 3 elements of a 4x4 write to id 2.
  - Response: all outputs 0 immediately and no write to 2304. After release, write_ready=1 on the 2nd cycle, and a new 1x1 request completes normally.
- **Ignored inputs**
  - Stimulus: data_valid in IDLE; write_request during DATA.
  - Response: no RAM write, no second latch; element count unaffected.

Source files
------------

// File: rtl/matrix_storage_writer.sv
`default_nettype none
// ============================================================================
// Module      : matrix_storage_writer
// Description : Lays one matrix per request into a fixed-size slot of the
//               storage RAM: two name words, row-major data, then the header
//               word last so a slot only reads as occupied once complete.
// Revision    : 1.0 - initial release
// ============================================================================
module matrix_storage_writer #(
    parameter int BLOCK_SIZE = 1152,
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 14
) (
    input  logic                  clk,
    input  logic                  rst_n,
    // request side
    input  logic                  write_request,
    output logic                  write_ready,
    input  logic [2:0]            matrix_id,
    input  logic [7:0]            actual_rows,
    input  logic [7:0]            actual_cols,
    input  logic [0:7][7:0]       matrix_name,
    // element stream
    input  logic [DATA_WIDTH-1:0] data_in,
    input  logic                  data_valid,
    output logic                  writer_ready,
    // status pulses
    output logic                  write_done,
    output logic                  error,
    // storage RAM write port
    output logic                  ram_wr_en,
    output logic [ADDR_WIDTH-1:0] ram_wr_addr,
    output logic [DATA_WIDTH-1:0] ram_wr_data
);

    // Slot geometry: header at +0, name words at +1/+2, data from +3.
    localparam logic [ADDR_WIDTH-1:0] c_BLOCK_ADDR = ADDR_WIDTH'(BLOCK_SIZE);
    localparam logic [ADDR_WIDTH-1:0] c_NAME1_OFS  = ADDR_WIDTH'(1);
    localparam logic [ADDR_WIDTH-1:0] c_NAME2_OFS  = ADDR_WIDTH'(2);
    localparam logic [ADDR_WIDTH-1:0] c_DATA_OFS   = ADDR_WIDTH'(3);
    localparam logic [16:0]           c_BLOCK_LIM  = 17'(BLOCK_SIZE);

    typedef enum logic [2:0] {
        S_RST_WAIT = 3'd0,
        S_IDLE     = 3'd1,
        S_NAME1    = 3'd2,
        S_NAME2    = 3'd3,
        S_DATA     = 3'd4,
        S_HDR      = 3'd5,
        S_DONE     = 3'd6,
        S_ERR      = 3'd7
    } state_t;

    // ------------------------------------------------------------------
    // State and latched request context
    // ------------------------------------------------------------------
    state_t                  state_q,  state_d;
    logic [ADDR_WIDTH-1:0]   base_q,   base_d;
    logic [7:0]              rows_q,   rows_d;
    logic [7:0]              cols_q,   cols_d;
    logic [0:7][7:0]         name_q,   name_d;
    logic [15:0]             total_q,  total_d;
    logic [15:0]             idx_q,    idx_d;

    // Registered Moore outputs (computed from the next state)
    logic                    write_ready_q,  write_ready_d;
    logic                    writer_ready_q, writer_ready_d;
    logic                    write_done_q,   write_done_d;
    logic                    error_q,        error_d;
    logic                    reg_wr_en_q,    reg_wr_en_d;
    logic [ADDR_WIDTH-1:0]   reg_wr_addr_q,  reg_wr_addr_d;
    logic [DATA_WIDTH-1:0]   reg_wr_data_q,  reg_wr_data_d;

    // Request decode
    logic [15:0]             w_req_total;
    logic [ADDR_WIDTH-1:0]   w_req_base;
    logic                    w_dims_ok;
    logic                    w_last_elem;

    assign w_req_total = {8'h00, actual_rows} * {8'h00, actual_cols};
    assign w_req_base  = ADDR_WIDTH'(matrix_id) * c_BLOCK_ADDR;
    // Three words of every slot are metadata, so the data must leave room.
    assign w_dims_ok   = (actual_rows != 8'd0) && (actual_cols != 8'd0) &&
                         (({1'b0, w_req_total} + 17'd3) <= c_BLOCK_LIM);
    assign w_last_elem = (idx_q == (total_q - 16'd1));

    // Next-state, context latch and next registered-output computation
    always_comb begin
        state_d  = state_q;
        base_d   = base_q;
        rows_d   = rows_q;
        cols_d   = cols_q;
        name_d   = name_q;
        total_d  = total_q;
        idx_d    = idx_q;

        case (state_q)
            S_RST_WAIT: state_d = S_IDLE;
            S_IDLE: begin
                if (write_request) begin
                    if (w_dims_ok) begin
                        state_d = S_NAME1;
                        base_d  = w_req_base;
                        rows_d  = actual_rows;
                        cols_d  = actual_cols;
                        name_d  = matrix_name;
                        total_d = w_req_total;
                        idx_d   = 16'd0;
                    end else begin
                        state_d = S_ERR;
                    end
                end
            end
            S_NAME1: state_d = S_NAME2;
            S_NAME2: state_d = S_DATA;
            S_DATA: begin
                if (data_valid) begin
                    idx_d = idx_q + 16'd1;
                    if (w_last_elem) begin
                        state_d = S_HDR;
                    end
                end
            end
            S_HDR:   state_d = S_DONE;
            S_DONE:  state_d = S_IDLE;
            S_ERR:   state_d = S_IDLE;
            default: state_d = S_RST_WAIT;
        endcase

        write_ready_d  = (state_d == S_IDLE);
        writer_ready_d = (state_d == S_DATA);
        write_done_d   = (state_d == S_DONE);
        error_d        = (state_d == S_ERR);

        reg_wr_en_d    = 1'b0;
        reg_wr_addr_d  = '0;
        reg_wr_data_d  = '0;
        case (state_d)
            S_NAME1: begin
                reg_wr_en_d   = 1'b1;
                reg_wr_addr_d = base_d + c_NAME1_OFS;
                reg_wr_data_d = DATA_WIDTH'({name_d[0], name_d[1], name_d[2], name_d[3]});
            end
            S_NAME2: begin
                reg_wr_en_d   = 1'b1;
                reg_wr_addr_d = base_d + c_NAME2_OFS;
                reg_wr_data_d = DATA_WIDTH'({name_d[4], name_d[5], name_d[6], name_d[7]});
            end
            S_HDR: begin
                reg_wr_en_d   = 1'b1;
                reg_wr_addr_d = base_d;
                reg_wr_data_d = DATA_WIDTH'({rows_d, cols_d});
            end
            default: begin
                reg_wr_en_d   = 1'b0;
            end
        endcase
    end

    // FSM register with registered outputs; reset aborts any write in flight
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= S_RST_WAIT;
            base_q         <= '0;
            rows_q         <= '0;
            cols_q         <= '0;
            name_q         <= '0;
            total_q        <= '0;
            idx_q          <= '0;
            write_ready_q  <= 1'b0;
            writer_ready_q <= 1'b0;
            write_done_q   <= 1'b0;
            error_q        <= 1'b0;
            reg_wr_en_q    <= 1'b0;
            reg_wr_addr_q  <= '0;
            reg_wr_data_q  <= '0;
        end else begin
            state_q        <= state_d;
            base_q         <= base_d;
            rows_q         <= rows_d;
            cols_q         <= cols_d;
            name_q         <= name_d;
            total_q        <= total_d;
            idx_q          <= idx_d;
            write_ready_q  <= write_ready_d;
            writer_ready_q <= writer_ready_d;
            write_done_q   <= write_done_d;
            error_q        <= error_d;
            reg_wr_en_q    <= reg_wr_en_d;
            reg_wr_addr_q  <= reg_wr_addr_d;
            reg_wr_data_q  <= reg_wr_data_d;
        end
    end

    // RAM port: element writes pass straight through while in DATA so an
    // element costs no extra cycle; all other writes come from registers.
    always_comb begin
        if (state_q == S_DATA) begin
            ram_wr_en   = data_valid;
            ram_wr_addr = base_q + c_DATA_OFS + ADDR_WIDTH'(idx_q);
            ram_wr_data = data_in;
        end else begin
            ram_wr_en   = reg_wr_en_q;
            ram_wr_addr = reg_wr_addr_q;
            ram_wr_data = reg_wr_data_q;
        end
    end

    assign write_ready  = write_ready_q;
    assign writer_ready = writer_ready_q;
    assign write_done   = write_done_q;
    assign error        = error_q;

endmodule
`default_nettype wire

// File: tb/tb_matrix_storage_writer.sv
`default_nettype none
// ============================================================================
// Module      : tb_matrix_storage_writer
// Description : Scoreboard bench for matrix_storage_writer. Stimulus pushes
//               expected RAM writes / pulses; a monitor pops and compares.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_matrix_storage_writer;

    localparam int KW = 0;  // RAM write
    localparam int KD = 1;  // write_done pulse
    localparam int KE = 2;  // error pulse

    logic             clk = 1'b0;
    logic             rst_n;
    logic             write_request;
    logic             write_ready;
    logic [2:0]       matrix_id;
    logic [7:0]       actual_rows;
    logic [7:0]       actual_cols;
    logic [0:7][7:0]  matrix_name;
    logic [31:0]      data_in;
    logic             data_valid;
    logic             writer_ready;
    logic             write_done;
    logic             error;
    logic             ram_wr_en;
    logic [13:0]      ram_wr_addr;
    logic [31:0]      ram_wr_data;

    matrix_storage_writer #(
        .BLOCK_SIZE (1152),
        .DATA_WIDTH (32),
        .ADDR_WIDTH (14)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .write_request (write_request),
        .write_ready   (write_ready),
        .matrix_id     (matrix_id),
        .actual_rows   (actual_rows),
        .actual_cols   (actual_cols),
        .matrix_name   (matrix_name),
        .data_in       (data_in),
        .data_valid    (data_valid),
        .writer_ready  (writer_ready),
        .write_done    (write_done),
        .error         (error),
        .ram_wr_en     (ram_wr_en),
        .ram_wr_addr   (ram_wr_addr),
        .ram_wr_data   (ram_wr_data)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          kind;
        logic [13:0] addr;
        logic [31:0] data;
    } exp_t;

    exp_t        exp_q[$];
    logic [31:0] stim_q[$];
    bit          vpat_q[$];
    int          n_checks = 0;
    int          n_errors = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
        n_checks++;
        if (act !== expv) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, expv);
        end
    endtask

    task automatic push_w(input logic [13:0] a, input logic [31:0] d);
        exp_t e;
        e.kind = KW; e.addr = a; e.data = d;
        exp_q.push_back(e);
    endtask

    task automatic push_ev(input int k);
        exp_t e;
        e.kind = k; e.addr = '0; e.data = '0;
        exp_q.push_back(e);
    endtask

    task automatic take(input int kind);
        exp_t e;
        n_checks++;
        if (exp_q.size() == 0) begin
            n_errors++;
            $display("FAIL unexpected_output: kind %0d addr %0d data 0x%08h, expected nothing",
                     kind, ram_wr_addr, ram_wr_data);
        end else begin
            e = exp_q.pop_front();
            if (e.kind != kind ||
                (kind == KW && (e.addr !== ram_wr_addr || e.data !== ram_wr_data))) begin
                n_errors++;
                $display("FAIL scoreboard: got kind %0d addr %0d data 0x%08h, expected kind %0d addr %0d data 0x%08h",
                         kind, ram_wr_addr, ram_wr_data, e.kind, e.addr, e.data);
            end
        end
    endtask

    task automatic monitor();
        forever begin
            @(negedge clk);
            if (ram_wr_en === 1'b1)  take(KW);
            if (write_done === 1'b1) take(KD);
            if (error === 1'b1)      take(KE);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_ready();
        int n = 0;
        while (write_ready !== 1'b1 && n < 50) begin
            tick();
            n++;
        end
        chk("wait_ready", 32'(write_ready), 32'd1);
    endtask

    // Issue one request and stream its elements; abort_after>=0 asserts reset
    // while the element with that index is being presented.
    task automatic drive_matrix(input logic [2:0] id, input logic [7:0] r, input logic [7:0] c,
                                input logic [63:0] nm, input int n, input int abort_after,
                                input bit poke);
        int sent = 0;
        int pi   = 0;
        bit v;
        bit aborted = 1'b0;
        wait_ready();
        write_request = 1'b1;
        matrix_id     = id;
        actual_rows   = r;
        actual_cols   = c;
        matrix_name   = nm;
        tick();
        write_request = 1'b0;
        chk("name1_not_ready", 32'(write_ready), 32'd0);
        tick();
        tick();
        chk("data_writer_ready", 32'(writer_ready), 32'd1);
        while (sent < n && !aborted) begin
            v = (pi < vpat_q.size()) ? vpat_q[pi] : 1'b1;
            pi++;
            data_valid = v;
            data_in    = v ? stim_q[sent] : 32'hDEADBEEF;
            if (poke) begin
                write_request = 1'b1;
                matrix_id     = id + 3'd1;
                actual_rows   = 8'd1;
                actual_cols   = 8'd1;
                matrix_name   = ~nm;
            end
            if (abort_after >= 0 && sent == abort_after) begin
                rst_n   = 1'b0;
                aborted = 1'b1;
            end else begin
                tick();
                if (v) sent++;
            end
        end
        if (!aborted) begin
            data_valid    = 1'b0;
            write_request = 1'b0;
        end
        vpat_q.delete();
        stim_q.delete();
    endtask

    // Called in the HDR cycle; checks the completion timing.
    task automatic finish_write();
        chk("hdr_writer_ready", 32'(writer_ready), 32'd0);
        tick();
        chk("done_not_ready", 32'(write_ready), 32'd0);
        tick();
        chk("ready_after_done", 32'(write_ready), 32'd1);
    endtask

    task automatic reject(input logic [2:0] id, input logic [7:0] r, input logic [7:0] c);
        wait_ready();
        push_ev(KE);
        write_request = 1'b1;
        matrix_id     = id;
        actual_rows   = r;
        actual_cols   = c;
        matrix_name   = 64'h5245_4A45_4354_4544;
        tick();
        write_request = 1'b0;
        chk("rej_busy", 32'(write_ready), 32'd0);
        tick();
        chk("rej_ready", 32'(write_ready), 32'd1);
    endtask

    initial begin
        #300000;
        $display("FAIL timeout: simulation did not finish, got no end, expected end");
        $fatal(1, "timeout");
    end

    initial begin
        rst_n         = 1'b0;
        write_request = 1'b0;
        matrix_id     = '0;
        actual_rows   = '0;
        actual_cols   = '0;
        matrix_name   = '0;
        data_in       = '0;
        data_valid    = 1'b0;
        fork
            monitor();
        join_none

        // Reset state
        tick();
        tick();
        chk("rst_write_ready",  32'(write_ready),  32'd0);
        chk("rst_writer_ready", 32'(writer_ready), 32'd0);
        chk("rst_ram_wr_en",    32'(ram_wr_en),    32'd0);
        chk("rst_write_done",   32'(write_done),   32'd0);
        chk("rst_error",        32'(error),        32'd0);
        rst_n = 1'b1;
        chk("rst_wait_ready", 32'(write_ready), 32'd0);
        tick();
        chk("ready_after_reset", 32'(write_ready), 32'd1);

        // Basic write: id 1, 2x3, "ABCDEFGH", data 1..6
        push_w(14'd1153, 32'h41424344);
        push_w(14'd1154, 32'h45464748);
        for (int k = 0; k < 6; k++) begin
            push_w(14'(1155 + k), 32'(k + 1));
            stim_q.push_back(32'(k + 1));
        end
        push_w(14'd1152, 32'h00000203);
        push_ev(KD);
        drive_matrix(3'd1, 8'd2, 8'd3, "ABCDEFGH", 6, -1, 1'b0);
        finish_write();

        // Bubbles: id 0, 2x2, valid pattern 1,0,0,1,1,0,1
        push_w(14'd1, 32'h5758595A);
        push_w(14'd2, 32'h30313233);
        push_w(14'd3, 32'd10);
        push_w(14'd4, 32'd20);
        push_w(14'd5, 32'd30);
        push_w(14'd6, 32'd40);
        push_w(14'd0, 32'h00000202);
        push_ev(KD);
        vpat_q = '{1, 0, 0, 1, 1, 0, 1};
        stim_q = '{32'd10, 32'd20, 32'd30, 32'd40};
        drive_matrix(3'd0, 8'd2, 8'd2, "WXYZ0123", 4, -1, 1'b0);
        finish_write();

        // Rejections: zero rows, and 34x34 which overflows the slot
        reject(3'd3, 8'd0, 8'd5);
        reject(3'd4, 8'd34, 8'd34);

        // Max slot: id 7, 33x34 (1122 elements)
        push_w(14'd8065, 32'h4D415853);
        push_w(14'd8066, 32'h4C4F5437);
        for (int k = 0; k < 1121; k++) begin
            push_w(14'(8067 + k), 32'h1000 + 32'(k));
        end
        push_w(14'd9188, 32'h00001461);
        push_w(14'd8064, 32'h00002122);
        push_ev(KD);
        for (int k = 0; k < 1122; k++) stim_q.push_back(32'h1000 + 32'(k));
        drive_matrix(3'd7, 8'd33, 8'd34, "MAXSLOT7", 1122, -1, 1'b0);
        finish_write();

        // Ignored inputs: data_valid in IDLE, then write_request during DATA
        data_valid = 1'b1;
        data_in    = 32'd99;
        tick();
        tick();
        data_valid = 1'b0;
        push_w(14'd5761, 32'h49474E4F);
        push_w(14'd5762, 32'h52454421);
        push_w(14'd5763, 32'd7);
        push_w(14'd5764, 32'd8);
        push_w(14'd5760, 32'h00000102);
        push_ev(KD);
        stim_q = '{32'd7, 32'd8};
        drive_matrix(3'd5, 8'd1, 8'd2, "IGNORED!", 2, -1, 1'b1);
        finish_write();

        // Reset in the middle of DATA for a 4x4 write to id 2
        push_w(14'd2305, 32'h52455345);
        push_w(14'd2306, 32'h544D4944);
        push_w(14'd2307, 32'hA0);
        push_w(14'd2308, 32'hA1);
        push_w(14'd2309, 32'hA2);
        stim_q = '{32'hA0, 32'hA1, 32'hA2, 32'hA3};
        drive_matrix(3'd2, 8'd4, 8'd4, "RESETMID", 16, 3, 1'b0);
        #1;
        chk("abort_ram_wr_en",    32'(ram_wr_en),    32'd0);
        chk("abort_ram_wr_addr",  32'(ram_wr_addr),  32'd0);
        chk("abort_ram_wr_data",  ram_wr_data,       32'd0);
        chk("abort_writer_ready", 32'(writer_ready), 32'd0);
        chk("abort_write_ready",  32'(write_ready),  32'd0);
        chk("abort_queue",        32'(exp_q.size()), 32'd0);
        tick();
        tick();
        rst_n      = 1'b1;
        data_valid = 1'b0;
        chk("abort_rst_wait", 32'(write_ready), 32'd0);
        tick();
        chk("abort_ready_2nd", 32'(write_ready), 32'd1);
        push_w(14'd2305, 32'h4F4E4542);
        push_w(14'd2306, 32'h594F4E45);
        push_w(14'd2307, 32'h55);
        push_w(14'd2304, 32'h00000101);
        push_ev(KD);
        stim_q = '{32'h55};
        drive_matrix(3'd2, 8'd1, 8'd1, "ONEBYONE", 1, -1, 1'b0);
        finish_write();

        repeat (5) tick();
        chk("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
